// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks fetch_pc through a combinational-read
// instruction memory and buffers {pc, instruction} pairs in a 2-entry FIFO for the decoder.
module fetch_sequencer #(
  parameter int          IMEM_BYTES = 88,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetchPc;
  logic [31:0] r_entryPc   [2];
  logic [31:0] r_entryData [2];
  logic        r_head;
  logic [1:0]  r_count;

  state_t      w_stateNext;
  logic [31:0] w_fetchPcNext;
  logic        w_push;
  logic        w_flush;
  logic        w_pop;
  logic        w_legal;
  logic        w_room;
  logic        w_tail;

  assign imem_addr  = r_fetchPc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_pc    = inst_valid ? r_entryPc[r_head]   : 32'h0;
  assign inst_data  = inst_valid ? r_entryData[r_head] : 32'h0;
  assign fault      = (r_state == FAULT);

  assign w_pop   = inst_valid && inst_ready;
  // 33-bit compare so a fetch_pc near 2^32 cannot wrap into the legal range
  assign w_legal = (r_fetchPc[1:0] == 2'b00) &&
                   (({1'b0, r_fetchPc} + 33'd4) <= 33'(IMEM_BYTES));
  assign w_room  = (r_count != 2'd2) || w_pop;
  assign w_tail  = r_head ^ r_count[0];

  always_comb begin
    w_stateNext   = r_state;
    w_fetchPcNext = r_fetchPc;
    w_push        = 1'b0;
    w_flush       = 1'b0;
    if (redirect_valid) begin
      w_flush       = 1'b1;
      w_fetchPcNext = redirect_pc;
      if (r_state == FAULT) w_stateNext = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (halt) begin
            w_stateNext = HALTED;
          end else if (w_room) begin
            if (w_legal) begin
              w_push        = 1'b1;
              w_fetchPcNext = r_fetchPc + 32'd4;
            end else begin
              w_stateNext = FAULT;
            end
          end
        end
        HALTED: begin
          if (!halt) w_stateNext = FETCH;
        end
        FAULT: begin
          w_stateNext = FAULT;
        end
        default: begin
          w_stateNext = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_fetchPc <= RESET_PC;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      r_state   <= w_stateNext;
      r_fetchPc <= w_fetchPcNext;
      if (w_flush) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) begin
          r_entryPc[w_tail]   <= r_fetchPc;
          r_entryData[w_tail] <= imem_rdata;
        end
        if (w_pop) r_head <= ~r_head;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
